// File: rtl/pid_hit_arbiter.sv
// pid_hit_arbiter
// Collects Electron/Muon/Pion flags from NCH fine-time channels. Each channel
// keeps one pending record: merged flags, first-hit timestamp and hit count.
// A round-robin arbiter moves at most one record per clock into a
// first-word-fall-through FIFO that drains through a valid/ready port.
//
// Handshake: a word transfers on any clk edge where out_valid && out_ready.
// out_valid only depends on FIFO occupancy, never on out_ready. While
// out_valid is high and out_ready is low, out_data holds the same head word.
//
// Word layout: [31]=E [30]=M [29]=P [28:24]=channel [23:16]=count [15:0]=ts.
module pid_hit_arbiter #(
  parameter int NCH        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NCH-1:0]                chan_mask,
  input  logic [NCH-1:0]                hit_e,
  input  logic [NCH-1:0]                hit_m,
  input  logic [NCH-1:0]                hit_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(NCH);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Timestamp counter and per-channel pending records
  logic [TS_W-1:0] r_ts_ctr;
  logic [NCH-1:0]  r_pend;
  logic [2:0]      r_flags [NCH];
  logic [TS_W-1:0] r_ts    [NCH];
  logic [7:0]      r_cnt   [NCH];
  logic [PW-1:0]   r_ptr;

  // Event FIFO
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic [NCH-1:0]  w_new;
  logic [NCH-1:0]  w_gnt_oh;
  logic            w_full;
  logic            w_rd;
  logic            w_hi_vld;
  logic            w_lo_vld;
  logic [PW-1:0]   w_hi_idx;
  logic [PW-1:0]   w_lo_idx;
  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [15:0]     w_ts16;
  logic [31:0]     w_gnt_word;

  assign w_new      = {NCH{enable}} & chan_mask & (hit_e | hit_m | hit_p);
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign out_valid  = (r_count != '0);
  assign w_rd       = out_valid & out_ready;
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign fifo_count = r_count;

  // Round-robin pick: lowest pending index at or above ptr, else lowest pending overall
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = PW'(i);
        if (PW'(i) >= r_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = PW'(i);
        end
      end
    end
    w_gnt_vld = !w_full && (w_hi_vld || w_lo_vld);
    w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    w_gnt_oh  = w_gnt_vld ? (NCH'(1) << w_gnt_idx) : '0;
  end

  // Format the granted channel's record into an event word
  always_comb begin
    w_ts16             = '0;
    w_ts16[TS_W-1:0]   = r_ts[w_gnt_idx];
    w_gnt_word         = {r_flags[w_gnt_idx], 5'(w_gnt_idx), r_cnt[w_gnt_idx], w_ts16};
  end

  // Free-running timestamp, wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ts_ctr <= '0;
    else     r_ts_ctr <= r_ts_ctr + 1'b1;
  end

  // Pending record update: load on first hit, merge while waiting, clear or reload on grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_flags[i] <= '0;
        r_ts[i]    <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_new[i]) begin
          if (!r_pend[i] || w_gnt_oh[i]) begin
            r_pend[i]  <= 1'b1;
            r_flags[i] <= {hit_e[i], hit_m[i], hit_p[i]};
            r_ts[i]    <= r_ts_ctr;
            r_cnt[i]   <= 8'd1;
          end else begin
            r_flags[i] <= r_flags[i] | {hit_e[i], hit_m[i], hit_p[i]};
            if (r_cnt[i] != 8'hFF) r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else if (w_gnt_oh[i]) begin
          r_pend[i]  <= 1'b0;
          r_flags[i] <= '0;
          r_ts[i]    <= '0;
          r_cnt[i]   <= '0;
        end
      end
    end
  end

  // Round-robin pointer moves past the channel just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_idx == PW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // FIFO pointers and occupancy; a grant only happens when not full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_gnt_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_gnt_vld, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents behind r_count are don't-care, so no reset needed
  always_ff @(posedge clk) begin
    if (w_gnt_vld) r_mem[r_wr_ptr] <= w_gnt_word;
  end

endmodule

// File: tb/tb_pid_hit_arbiter.sv
// Bench for pid_hit_arbiter: randomized and directed scenarios against a
// cycle-level behavioural model built from queues and arrays.
module tb_pid_hit_arbiter;

  localparam int NCH   = 8;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [NCH-1:0]  chan_mask = '0;
  logic [NCH-1:0]  hit_e = '0;
  logic [NCH-1:0]  hit_m = '0;
  logic [NCH-1:0]  hit_p = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [31:0]     out_data;
  logic [4:0]      fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit          m_pend  [NCH];
  logic [2:0]  m_flags [NCH];
  int          m_ts    [NCH];
  int          m_cnt   [NCH];
  int          m_ptr;
  int          m_ts_ctr;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  pid_hit_arbiter #(.NCH(NCH), .FIFO_DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .chan_mask  (chan_mask),
    .hit_e      (hit_e),
    .hit_m      (hit_m),
    .hit_p      (hit_p),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i]  = 1'b0;
      m_flags[i] = 3'b000;
      m_ts[i]    = 0;
      m_cnt[i]   = 0;
    end
    m_ptr    = 0;
    m_ts_ctr = 0;
    exp_q.delete();
  endfunction

  // One clock of the readout system, described from its rules
  function automatic void model_step();
    int  g;
    int  c;
    bit  full;
    full = (exp_q.size() >= DEPTH);
    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    g = -1;
    if (!full) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_q.push_back({m_flags[g], 5'(g), 8'(m_cnt[g]), 16'(m_ts[g])});
      m_ptr     = (g + 1) % NCH;
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (enable && chan_mask[i] && (hit_e[i] || hit_m[i] || hit_p[i])) begin
        if (m_pend[i]) begin
          m_flags[i] = m_flags[i] | {hit_e[i], hit_m[i], hit_p[i]};
          m_cnt[i]   = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
        end else begin
          m_pend[i]  = 1'b1;
          m_flags[i] = {hit_e[i], hit_m[i], hit_p[i]};
          m_ts[i]    = m_ts_ctr;
          m_cnt[i]   = 1;
        end
      end
    end
    m_ts_ctr = (m_ts_ctr + 1) % 65536;
  endfunction

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NCH; i++) r = r | m_pend[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
  endfunction

  // Advance one clock: record any word the DUT hands over, step the model
  task automatic tick();
    if (out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hit_e = '0; hit_m = '0; hit_p = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    n_checks++;
    if (fifo_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_single_hit();
    logic [31:0] held;
    enable = 1'b1; chan_mask = '1; out_ready = 1'b0;
    for (int c = 0; c < 100 && m_ts_ctr != 16'h0010; c++) tick();
    hit_e = 8'h08;
    tick();
    hit_e = '0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_one_clk: out_valid got %b want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h83010010) begin
      n_errors++; $display("FAIL single_word: got valid=%b data=%h want 1 83010010", out_valid, out_data);
    end
    held = out_data;
    repeat (3) tick();
    n_checks++;
    if (out_data !== held || fifo_count !== 5'd1) begin
      n_errors++; $display("FAIL single_hold: got data=%h count=%0d want %h 1", out_data, fifo_count, held);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_errors++; $display("FAIL single_drain: got valid=%b count=%0d want 0 0", out_valid, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    want[0] = 32'h45010020; want[1] = 32'h45010021; want[2] = 32'h45010022;
    enable = 1'b1; chan_mask = '1; out_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 100 && m_ts_ctr != 16'h0020; c++) tick();
    for (int c = 0; c < 10; c++) begin
      hit_m = (c < 3) ? 8'h20 : 8'h00;
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL b2b_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_m = '0;
    n_checks++;
    if (got_q.size() != 3) begin
      n_errors++; $display("FAIL b2b_count: got %0d words want 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_q[k] !== want[k]) begin
          n_errors++; $display("FAIL b2b_word%0d: got %h want %h", k, got_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] w;
    int want3 [3];
    int want2 [2];
    want3[0] = 7; want3[1] = 0; want3[2] = 2;
    want2[0] = 4; want2[1] = 1;
    do_reset();
    enable = 1'b1; chan_mask = '1; out_ready = 1'b1;
    hit_e = 8'h04; tick(); hit_e = '0;
    repeat (4) tick();
    got_q.delete();
    hit_m = 8'h85; tick(); hit_m = '0;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || any_pend()); c++) begin
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL rr_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    tick();
    n_checks++;
    if (got_q.size() != 3) begin
      n_errors++; $display("FAIL rr_count3: got %0d words want 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        w = got_q[k];
        n_checks++;
        if (int'(w[28:24]) != want3[k]) begin
          n_errors++; $display("FAIL rr_order%0d: got ch%0d want ch%0d", k, w[28:24], want3[k]);
        end
      end
    end
    // Pointer should now sit at 3: ch4 must beat ch1
    got_q.delete();
    hit_p = 8'h12; tick(); hit_p = '0;
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 2) begin
      n_errors++; $display("FAIL rr_count2: got %0d words want 2", got_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        w = got_q[k];
        n_checks++;
        if (int'(w[28:24]) != want2[k]) begin
          n_errors++; $display("FAIL rr_ptr%0d: got ch%0d want ch%0d", k, w[28:24], want2[k]);
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    logic [2:0]  v;
    logic [31:0] w;
    int total;
    int sum;
    int ch_sum [NCH];
    do_reset();
    enable = 1'b1; chan_mask = '1; out_ready = 1'b0;
    total = 0;
    for (int i = 0; i < NCH; i++) ch_sum[i] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NCH; i++) begin
        v = 3'($urandom_range(1, 7));
        hit_e[i] = v[2]; hit_m[i] = v[1]; hit_p[i] = v[0];
      end
      total += NCH;
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL full_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_e = '0; hit_m = '0; hit_p = '0;
    n_checks++;
    if (fifo_count !== 5'd16) begin
      n_errors++; $display("FAIL full_level: got %0d want 16", fifo_count);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || any_pend()); c++) begin
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL drain_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_timeout: out_valid got %b want 0", out_valid);
    end
    sum = 0;
    foreach (got_q[k]) begin
      w = got_q[k];
      sum += int'(w[23:16]);
      if (int'(w[28:24]) < NCH) ch_sum[w[28:24]] += int'(w[23:16]);
    end
    n_checks++;
    if (sum != total) begin
      n_errors++; $display("FAIL full_hit_sum: got %0d want %0d", sum, total);
    end
    for (int i = 0; i < NCH; i++) begin
      n_checks++;
      if (ch_sum[i] != 40) begin
        n_errors++; $display("FAIL full_ch%0d_sum: got %0d want 40", i, ch_sum[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] w;
    int max_cnt;
    do_reset();
    enable = 1'b1; chan_mask = '1; out_ready = 1'b0;
    hit_e = '1;
    repeat (20) tick();
    hit_e = 8'h01;
    for (int c = 0; c < 280; c++) begin
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL sat_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_e = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || any_pend()); c++) tick();
    tick();
    max_cnt = 0;
    foreach (got_q[k]) begin
      w = got_q[k];
      if (w[28:24] == 5'd0 && int'(w[23:16]) > max_cnt) max_cnt = int'(w[23:16]);
    end
    n_checks++;
    if (max_cnt != 255) begin
      n_errors++; $display("FAIL sat_cnt: got %0d want 255", max_cnt);
    end
  endtask

  task automatic test_enable_mask();
    logic [31:0] w;
    bit saw4;
    do_reset();
    enable = 1'b1; chan_mask = '1; out_ready = 1'b1;
    hit_e = 8'h02; tick(); hit_e = '0;
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hit_e = 8'($urandom); hit_m = 8'($urandom); hit_p = 8'($urandom);
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL en_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_e = '0; hit_m = '0; hit_p = '0;
    n_checks++;
    if (got_q.size() != 1) begin
      n_errors++; $display("FAIL en_words: got %0d words want 1", got_q.size());
    end else begin
      w = got_q[0];
      n_checks++;
      if (w[31:24] !== 8'h81) begin
        n_errors++; $display("FAIL en_ch1: got flags/ch %h want 81", w[31:24]);
      end
    end
    got_q.delete();
    enable = 1'b1; chan_mask = 8'hEF;
    for (int c = 0; c < 30; c++) begin
      hit_e = 8'($urandom); hit_m = 8'($urandom); hit_p = 8'($urandom);
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL mask_cycle: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_e = '0; hit_m = '0; hit_p = '0;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || any_pend()); c++) tick();
    tick();
    saw4 = 1'b0;
    foreach (got_q[k]) begin
      w = got_q[k];
      if (w[28:24] == 5'd4) saw4 = 1'b1;
    end
    n_checks++;
    if (saw4 || got_q.size() == 0) begin
      n_errors++; $display("FAIL mask_ch4: got saw_ch4=%b words=%0d want 0 and >0", saw4, got_q.size());
    end
    chan_mask = '1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) chan_mask = 8'($urandom);
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      hit_e = 8'($urandom & $urandom & $urandom);
      hit_m = 8'($urandom & $urandom & $urandom);
      hit_p = 8'($urandom & $urandom & $urandom);
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size()) ||
          (exp_q.size() != 0 && out_data !== exp_q[0])) begin
        n_errors++;
        $display("FAIL rand_cycle%0d: got valid=%b count=%0d data=%h want valid=%b count=%0d data=%h",
                 c, out_valid, fifo_count, out_data, exp_q.size() != 0, exp_q.size(), exp_head());
      end
    end
    hit_e = '0; hit_m = '0; hit_p = '0;
    chan_mask = '1; enable = 1'b1;
  endtask

  task automatic test_ts_wrap_and_reset();
    do_reset();
    enable = 1'b1; chan_mask = '1; out_ready = 1'b1;
    for (int c = 0; c < 70000 && m_ts_ctr != 16'hFFFF; c++) tick();
    got_q.delete();
    hit_p = 8'h40; tick(); tick(); hit_p = '0;
    repeat (5) tick();
    n_checks++;
    if (got_q.size() != 2) begin
      n_errors++; $display("FAIL wrap_words: got %0d want 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 32'h2601FFFF) begin
        n_errors++; $display("FAIL wrap_ffff: got %h want 2601FFFF", got_q[0]);
      end
      n_checks++;
      if (got_q[1] !== 32'h26010000) begin
        n_errors++; $display("FAIL wrap_0000: got %h want 26010000", got_q[1]);
      end
    end
    // Park five words in the FIFO, then reset mid-cycle
    out_ready = 1'b0;
    hit_e = 8'h1F; tick(); hit_e = '0;
    repeat (5) tick();
    n_checks++;
    if (fifo_count !== 5'd5) begin
      n_errors++; $display("FAIL five_words: got %0d want 5", fifo_count);
    end
    #4 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0 || out_data !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset: got valid=%b count=%0d data=%h want 0 0 00000000", out_valid, fifo_count, out_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || fifo_count !== 5'(exp_q.size())) begin
        n_errors++;
        $display("FAIL post_reset: got valid=%b count=%0d want valid=%b count=%0d",
                 out_valid, fifo_count, exp_q.size() != 0, exp_q.size());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_round_robin();
    test_full_backpressure();
    test_saturation();
    test_enable_mask();
    test_random();
    test_ts_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
